// File: rtl/scan_pkg.sv
// Shared definitions for the scan test sequencer: state encoding, counter width
// and default core dimensions.
package scan_pkg;

  localparam int unsigned FailCntW    = 8;
  localparam int unsigned DefChainLen = 3;
  localparam int unsigned DefNpi      = 4;
  localparam int unsigned DefNpo      = 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCapt,
    StUnload,
    StDone
  } scan_state_e;

endpackage

// File: rtl/scan_bit_counter.sv
// Down-counter timing one pass over the scan chain; loads CHAIN_LEN-1 and flags zero.
module scan_bit_counter #(
  parameter int unsigned CHAIN_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(CHAIN_LEN - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/scan_test_ctrl.sv
// Runs one scan test per START: shift load, single capture, shift unload, then
// compares the unloaded state and captured outputs against the expected values.
module scan_test_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DefChainLen,
  parameter int unsigned NPI       = DefNpi,
  parameter int unsigned NPO       = DefNpo
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic [NPI-1:0]       PI_VEC,
  input  logic [CHAIN_LEN-1:0] EXP_RESP,
  input  logic [NPO-1:0]       EXP_PO,
  input  logic                 SO,
  input  logic [NPO-1:0]       PO,
  output logic                 SE,
  output logic                 SI,
  output logic [NPI-1:0]       PI_OUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic [NPO-1:0]       PO_CAP,
  output logic [FailCntW-1:0]  FAIL_CNT
);

  scan_state_e state_d, state_q;

  logic                 se_d, se_q;
  logic                 si_d, si_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;
  logic                 pass_d, pass_q;
  logic [NPI-1:0]       pi_out_d, pi_out_q;
  logic [CHAIN_LEN-1:0] pat_d, pat_q;
  logic [CHAIN_LEN-1:0] exp_resp_d, exp_resp_q;
  logic [NPO-1:0]       exp_po_d, exp_po_q;
  logic [CHAIN_LEN-1:0] resp_d, resp_q;
  logic [NPO-1:0]       po_cap_d, po_cap_q;
  logic [FailCntW-1:0]  fail_cnt_d, fail_cnt_q;

  logic cnt_load, cnt_en, cnt_tc;

  scan_bit_counter #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_bit_counter (
    .clk_i  (CK),
    .rst_i  (RST),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    se_d       = 1'b0;
    si_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    pi_out_d   = pi_out_q;
    pat_d      = pat_q;
    exp_resp_d = exp_resp_q;
    exp_po_d   = exp_po_q;
    resp_d     = resp_q;
    po_cap_d   = po_cap_q;
    fail_cnt_d = fail_cnt_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          // The MSB goes out on SI straight away; the rest is queued in pat_q.
          pi_out_d   = PI_VEC;
          pat_d      = PAT << 1;
          exp_resp_d = EXP_RESP;
          exp_po_d   = EXP_PO;
          se_d       = 1'b1;
          si_d       = PAT[CHAIN_LEN-1];
          busy_d     = 1'b1;
          cnt_load   = 1'b1;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = StCapt;
        end else begin
          se_d  = 1'b1;
          si_d  = pat_q[CHAIN_LEN-1];
          pat_d = pat_q << 1;
        end
      end
      StCapt: begin
        po_cap_d = PO;
        se_d     = 1'b1;
        cnt_load = 1'b1;
        state_d  = StUnload;
      end
      StUnload: begin
        cnt_en = 1'b1;
        resp_d = (resp_q << 1) | CHAIN_LEN'(SO);
        if (cnt_tc) begin
          // Compare against resp_d so the final sample taken on this edge counts.
          pass_d  = (resp_d == exp_resp_q) && (po_cap_q == exp_po_q);
          done_d  = 1'b1;
          state_d = StDone;
          if (!pass_d && (fail_cnt_q != '1)) begin
            fail_cnt_d = fail_cnt_q + FailCntW'(1);
          end
        end else begin
          se_d = 1'b1;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q    <= StIdle;
      se_q       <= 1'b0;
      si_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      pi_out_q   <= '0;
      pat_q      <= '0;
      exp_resp_q <= '0;
      exp_po_q   <= '0;
      resp_q     <= '0;
      po_cap_q   <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      se_q       <= se_d;
      si_q       <= si_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      pi_out_q   <= pi_out_d;
      pat_q      <= pat_d;
      exp_resp_q <= exp_resp_d;
      exp_po_q   <= exp_po_d;
      resp_q     <= resp_d;
      po_cap_q   <= po_cap_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign SE       = se_q;
  assign SI       = si_q;
  assign PI_OUT   = pi_out_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign RESP     = resp_q;
  assign PO_CAP   = po_cap_q;
  assign FAIL_CNT = fail_cnt_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl with a behavioural 3-flop s27-style stub core.
module tb_scan_test_ctrl;

  localparam int N   = 3;
  localparam int NPI = 4;
  localparam int NPO = 1;

  logic           CK = 1'b0;
  logic           RST = 1'b1;
  logic           START = 1'b0;
  logic [N-1:0]   PAT = '0;
  logic [NPI-1:0] PI_VEC = '0;
  logic [N-1:0]   EXP_RESP = '0;
  logic [NPO-1:0] EXP_PO = '0;
  logic           SO;
  logic [NPO-1:0] PO;
  logic           SE, SI, BUSY, DONE, PASS;
  logic [NPI-1:0] PI_OUT;
  logic [N-1:0]   RESP;
  logic [NPO-1:0] PO_CAP;
  logic [7:0]     FAIL_CNT;

  int n_checks = 0;
  int n_errors = 0;
  int m_fail   = 0;

  always #5 CK = ~CK;

  // Stub core: chain[0] nearest SI, chain[2] drives SO; capture loads PI[2:0].
  logic [N-1:0] chain = '0;
  always @(posedge CK) chain <= SE ? {chain[N-2:0], SI} : PI_OUT[N-1:0];
  assign SO = chain[N-1];
  assign PO = {(^chain) ^ PI_OUT[3]};

  scan_test_ctrl #(
    .CHAIN_LEN (N),
    .NPI       (NPI),
    .NPO       (NPO)
  ) dut (
    .CK       (CK),
    .RST      (RST),
    .START    (START),
    .PAT      (PAT),
    .PI_VEC   (PI_VEC),
    .EXP_RESP (EXP_RESP),
    .EXP_PO   (EXP_PO),
    .SO       (SO),
    .PO       (PO),
    .SE       (SE),
    .SI       (SI),
    .PI_OUT   (PI_OUT),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .PASS     (PASS),
    .RESP     (RESP),
    .PO_CAP   (PO_CAP),
    .FAIL_CNT (FAIL_CNT)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // At capture the chain holds PAT, so PO reflects the loaded pattern.
  function automatic logic model_po(input logic [N-1:0] pat, input logic [NPI-1:0] pi);
    return (^pat) ^ pi[3];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".se"}, 32'(SE), 0);
    check_eq({tag, ".si"}, 32'(SI), 0);
    check_eq({tag, ".pi_out"}, 32'(PI_OUT), 0);
    check_eq({tag, ".busy"}, 32'(BUSY), 0);
    check_eq({tag, ".done"}, 32'(DONE), 0);
    check_eq({tag, ".pass"}, 32'(PASS), 0);
    check_eq({tag, ".resp"}, 32'(RESP), 0);
    check_eq({tag, ".po_cap"}, 32'(PO_CAP), 0);
    check_eq({tag, ".fail_cnt"}, 32'(FAIL_CNT), 0);
  endtask

  // Called at a negedge; START is sampled on the following posedge (t0).
  task automatic apply_start(input logic [N-1:0] pat, input logic [NPI-1:0] pi,
                             input logic [N-1:0] er, input logic ep);
    PAT = pat; PI_VEC = pi; EXP_RESP = er; EXP_PO = ep; START = 1'b1;
    @(posedge CK);
    #1;
    START = 1'b0;
    // Scramble inputs: the DUT must have latched them on the accept edge.
    PAT = N'($urandom); PI_VEC = NPI'($urandom);
    EXP_RESP = N'($urandom); EXP_PO = NPO'($urandom);
  endtask

  // Full test, cycle-by-cycle against the timing schedule; s1/s2 inject stray STARTs.
  task automatic run_test(input logic [N-1:0] pat, input logic [NPI-1:0] pi,
                          input logic [N-1:0] er, input logic ep,
                          input int s1, input int s2);
    logic [N-1:0] e_resp;
    logic         e_po, e_pass;
    logic         se_e, si_e;
    e_resp = pi[N-1:0];
    e_po   = model_po(pat, pi);
    e_pass = (e_resp == er) && (e_po == ep);
    if (!e_pass && m_fail < 255) m_fail++;
    apply_start(pat, pi, er, ep);
    for (int k = 1; k <= 2 * N + 5; k++) begin
      @(negedge CK);
      se_e = (k <= N) || (k >= N + 2 && k <= 2 * N + 1);
      si_e = (k <= N) ? pat[N-k] : 1'b0;
      check_eq("se", 32'(SE), 32'(se_e));
      check_eq("si", 32'(SI), 32'(si_e));
      check_eq("busy", 32'(BUSY), 32'(k <= 2 * N + 2));
      check_eq("done", 32'(DONE), 32'(k == 2 * N + 2));
      check_eq("pi_out", 32'(PI_OUT), 32'(pi));
      if (k == 2 * N + 2) begin
        check_eq("resp", 32'(RESP), 32'(e_resp));
        check_eq("po_cap", 32'(PO_CAP), 32'(e_po));
        check_eq("pass", 32'(PASS), 32'(e_pass));
        check_eq("fail_cnt", 32'(FAIL_CNT), 32'(m_fail));
      end
      START = (k == s1) || (k == s2);
    end
    START = 1'b0;
  endtask

  initial begin
    logic [N-1:0]   r_pat, r_er;
    logic [NPI-1:0] r_pi;
    logic           r_ep;

    // Reset held for two cycles
    RST = 1'b1;
    repeat (2) @(posedge CK);
    @(negedge CK);
    check_reset_outputs("rst");
    START = 1'b1;
    @(negedge CK);
    check_eq("rst_start.busy", 32'(BUSY), 0);
    check_eq("rst_start.se", 32'(SE), 0);
    START = 1'b0;
    RST = 1'b0;

    // Directed pass, then two failing runs
    run_test(3'b101, 4'b0101, 3'b101, 1'b0, -1, -1);
    run_test(3'b101, 4'b0101, 3'b100, 1'b0, -1, -1);
    run_test(3'b101, 4'b0101, 3'b100, 1'b0, -1, -1);

    // START during LOAD and during DONE must be ignored
    run_test(3'b011, 4'b1110, 3'b110, model_po(3'b011, 4'b1110), 3, 2 * N + 2);

    // Mid-LOAD reset aborts the test and clears FAIL_CNT
    apply_start(3'b110, 4'b0011, 3'b000, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge CK);
      if (k == 2) RST = 1'b1;
      if (k >= 3) begin
        check_eq("abort.se", 32'(SE), 0);
        check_eq("abort.busy", 32'(BUSY), 0);
        check_eq("abort.done", 32'(DONE), 0);
        check_eq("abort.fail_cnt", 32'(FAIL_CNT), 0);
      end
      if (k == 3) RST = 1'b0;
    end
    m_fail = 0;
    run_test(3'b010, 4'b1001, 3'b001, model_po(3'b010, 4'b1001), -1, -1);

    // Randomized tests, roughly half expected to pass
    for (int i = 0; i < 40; i++) begin
      r_pat = N'($urandom);
      r_pi  = NPI'($urandom);
      r_er  = ($urandom_range(0, 1) == 1) ? r_pi[N-1:0] : N'($urandom);
      r_ep  = ($urandom_range(0, 3) != 0) ? model_po(r_pat, r_pi) : 1'($urandom);
      run_test(r_pat, r_pi, r_er, r_ep, -1, -1);
    end

    // Saturation: 256 guaranteed failures
    for (int i = 0; i < 256; i++) begin
      r_pat = N'($urandom);
      r_pi  = NPI'($urandom);
      run_test(r_pat, r_pi, ~r_pi[N-1:0], model_po(r_pat, r_pi), -1, -1);
    end
    check_eq("sat.fail_cnt", 32'(FAIL_CNT), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
